// File: rtl/sram_controller.sv
// Two-phase 16-bit SRAM sequencer for 32-bit MEM-stage loads/stores.
// The low halfword is accessed first, then the high halfword; ready gates the pipeline.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrEn,
  input  logic               rdEn,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic [15:0]        sramDqOut,
  input  logic [15:0]        sramDqIn,
  output logic               sramDqOe,
  output logic               sramWeN
);

  localparam int unsigned CntW = $clog2(WAIT_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(WAIT_CYCLES - 1);
  localparam logic [31:0] BaseAddr = 32'(BASE_ADDR);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               is_wr_q, is_wr_d;
  logic [SRAM_AW-2:0] offset_q, offset_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;

  logic [31:0] addr_diff;
  logic        term;
  logic        active_d;
  logic        unused_diff;

  assign addr_diff   = address - BaseAddr;
  // Only the halfword-pair index survives; upper offset bits wrap.
  assign unused_diff = ^{addr_diff[31:SRAM_AW+1], addr_diff[1:0]};
  assign term        = (cnt_q == LastCnt);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    offset_d = offset_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (rdEn || wrEn) begin
          state_d  = StLo;
          cnt_d    = '0;
          is_wr_d  = wrEn;
          offset_d = addr_diff[SRAM_AW:2];
          wdata_d  = writeData;
        end
      end
      StLo: begin
        if (term) begin
          state_d = StHi;
          cnt_d   = '0;
          if (!is_wr_q) rdata_d[15:0] = sramDqIn;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHi: begin
        if (term) begin
          state_d = StDone;
          cnt_d   = '0;
          if (!is_wr_q) rdata_d[31:16] = sramDqIn;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Pin outputs are decoded from the next state so they are registered yet cycle-aligned.
    active_d = (state_d == StLo) || (state_d == StHi);
    dq_oe_d  = active_d && is_wr_d;
    we_n_d   = !(dq_oe_d && (cnt_d != LastCnt));
    dq_out_d = '0;
    if (dq_oe_d) dq_out_d = (state_d == StHi) ? wdata_d[31:16] : wdata_d[15:0];
    addr_d   = active_d ? {offset_d, (state_d == StHi)} : addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_wr_q  <= 1'b0;
      offset_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      we_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      offset_q <= offset_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      we_n_q   <= we_n_d;
    end
  end

  assign ready     = ((state_q == StIdle) && !rdEn && !wrEn) || (state_q == StDone);
  assign readData  = rdata_q;
  assign sramAddr  = addr_q;
  assign sramDqOut = dq_out_q;
  assign sramDqOe  = dq_oe_q;
  assign sramWeN   = we_n_q;

endmodule
